dotprod_vec: RTL

Parametrised, multi-lane streaming dot-product engine; successor to the scalar `dotprod` datapath. For each job it takes a vector length `n` and a stream of operand beats, each beat carrying `LANES` element pairs. It accumulates the sum of `a[i]*b[i]` through a 3-stage multiply / adder-tree / accumulate pipeline. It sits between the operand fetch logic and the result register file, and is controlled by a start/done handshake.

---
 rtl/dotprod_vec.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/dotprod_vec.sv
// dotprod_vec: multi-lane streaming dot-product engine.
// Each job latches an element count, consumes LANES element pairs per beat,
// and sums a[i]*b[i] through multiply / adder-tree / accumulate stages.
module dotprod_vec #(
    parameter int DATA_W = 16,
    parameter int LANES  = 4,
    parameter int ACC_W  = 48,
    parameter bit SIGNED = 1'b1
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic                    start,
    input  logic [31:0]             n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] a_data,
    input  logic [LANES*DATA_W-1:0] b_data,
    output logic                    busy,
    output logic                    done,
    output logic [ACC_W-1:0]        return_val
);
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        remain_q, remain_d;
    logic               s1_v_q, s1_v_d;
    logic [PROD_W-1:0]  s1_prod_q [LANES];
    logic [PROD_W-1:0]  s1_prod_d [LANES];
    logic               s2_v_q, s2_v_d;
    logic [ACC_W-1:0]   s2_sum_q, s2_sum_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   ret_q, ret_d;
    logic               done_q, done_d;

    logic start_ok;
    logic beat_ok;
    logic last_beat;
    logic drain_exit;

    // Full-width product of one lane, operands extended according to SIGNED.
    function automatic logic [PROD_W-1:0] lane_product(input logic [DATA_W-1:0] a,
                                                       input logic [DATA_W-1:0] b);
        logic [PROD_W-1:0] a_x;
        logic [PROD_W-1:0] b_x;
        if (SIGNED) begin
            a_x = PROD_W'($signed(a));
            b_x = PROD_W'($signed(b));
        end else begin
            a_x = PROD_W'(a);
            b_x = PROD_W'(b);
        end
        return a_x * b_x;
    endfunction

    // Product widened to accumulator width with the same signedness.
    function automatic logic [ACC_W-1:0] widen(input logic [PROD_W-1:0] p);
        if (SIGNED) begin
            return ACC_W'($signed(p));
        end
        return ACC_W'(p);
    endfunction

    // A start arriving in the done cycle is dropped; the job is not over until then.
    assign start_ok  = (state_q == IDLE) && start && !done_q;
    assign beat_ok   = (state_q == RUN) && in_valid;
    assign last_beat = (remain_q <= 32'(LANES));
    // With S1 empty, any S2 sum is absorbed on this edge, so acc_d is the final result.
    assign drain_exit = (state_q == DRAIN) && !s1_v_q;

    // State register.
    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
        if (sys_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok) state_d = (n == 32'd0) ? DRAIN : RUN;
            RUN:     if (beat_ok && last_beat) state_d = DRAIN;
            DRAIN:   if (drain_exit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state; busy covers the done cycle too.
    always_comb begin
        in_ready = (state_q == RUN);
        busy     = (state_q != IDLE) || done_q;
    end

    assign done       = done_q;
    assign return_val = ret_q;

    // Datapath next values: element countdown, lane masking, adder tree, accumulate.
    always_comb begin
        // NOTE: every _d starts from a default so no branch can infer a latch.
        remain_d = remain_q;
        s1_v_d   = beat_ok;
        s2_v_d   = s1_v_q;
        s2_sum_d = s2_sum_q;
        acc_d    = acc_q;
        ret_d    = ret_q;
        done_d   = drain_exit;
        for (int k = 0; k < LANES; k++) begin
            s1_prod_d[k] = s1_prod_q[k];
        end

        if (start_ok) begin
            remain_d = n;
        end else if (beat_ok) begin
            remain_d = last_beat ? 32'd0 : remain_q - 32'(LANES);
        end

        if (beat_ok) begin
            for (int k = 0; k < LANES; k++) begin
                if (32'(k) < remain_q) begin
                    s1_prod_d[k] = lane_product(a_data[k*DATA_W +: DATA_W],
                                                b_data[k*DATA_W +: DATA_W]);
                end else begin
                    s1_prod_d[k] = '0;
                end
            end
        end

        if (s1_v_q) begin
            s2_sum_d = '0;
            for (int k = 0; k < LANES; k++) begin
                s2_sum_d = s2_sum_d + widen(s1_prod_q[k]);
            end
        end

        if (start_ok) begin
            acc_d = '0;
            ret_d = '0;
        end else begin
            if (s2_v_q) begin
                acc_d = acc_q + s2_sum_q;
            end
            if (drain_exit) begin
                ret_d = acc_d;
            end
        end
    end

    // Job-owned registers: cleared by reset, including mid-job.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            remain_q <= '0;
            s1_v_q   <= 1'b0;
            s2_v_q   <= 1'b0;
            acc_q    <= '0;
            ret_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            remain_q <= remain_d;
            s1_v_q   <= s1_v_d;
            s2_v_q   <= s2_v_d;
            acc_q    <= acc_d;
            ret_q    <= ret_d;
            done_q   <= done_d;
        end
    end

    // Pipeline data registers.
    always_ff @(posedge sys_clk) begin
        // NOTE: data registers carry no reset; their valid bits decide when they are used.
        s1_prod_q <= s1_prod_d;
        s2_sum_q  <= s2_sum_d;
    end

endmodule
